// File: rtl/alu_result_stage_if.sv
// rtl/alu_result_stage_if.sv - ALU result input and writeback handshake bundle.
// The stage connects via the slave modport; the ALU/register-file side uses master.
interface alu_result_stage_if #(
   parameter int WIDTH  = 16,
   parameter int DEST_W = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  alu_out;
   logic              alu_c_out;
   logic [3:0]        alu_sel_in;
   logic [DEST_W-1:0] dest_in;
   logic              wr_flags_in;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  wb_data;
   logic [DEST_W-1:0] wb_dest;

   modport master (
      output in_valid, alu_out, alu_c_out, alu_sel_in, dest_in, wr_flags_in, out_ready,
      input  in_ready, out_valid, wb_data, wb_dest
   );

   modport slave (
      input  in_valid, alu_out, alu_c_out, alu_sel_in, dest_in, wr_flags_in, out_ready,
      output in_ready, out_valid, wb_data, wb_dest
   );
endinterface

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - ALU result buffer with flag register and writeback handshake.
// Macro ALU_RESULT_SKID_EN selects a 2-entry skid buffer with registered in_ready.
module alu_result_stage #(
   parameter int WIDTH  = 16,
   parameter int DEST_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   alu_result_stage_if.slave    bus,
   input  logic                 flags_clr,
   output logic                 flag_c,
   output logic                 flag_z,
   output logic                 flag_n,
   output logic [1:0]           occupancy
);
   logic              accept;
   logic              xfer;
   logic [1:0]        occ_q;
   logic [1:0]        occ_d;
   logic [WIDTH-1:0]  head_data;
   logic [DEST_W-1:0] head_dest;

   assign accept        = bus.in_valid && bus.in_ready;
   assign xfer          = (occ_q != 2'd0) && bus.out_ready;
   assign occ_d         = occ_q + {1'b0, accept} - {1'b0, xfer};
   assign occupancy     = occ_q;
   assign bus.out_valid = (occ_q != 2'd0);
   assign bus.wb_data   = head_data;
   assign bus.wb_dest   = head_dest;

`ifdef ALU_RESULT_SKID_EN
   logic              ready_q;
   logic [WIDTH-1:0]  skid_data;
   logic [DEST_W-1:0] skid_dest;

   assign bus.in_ready = ready_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q     <= 2'd0;
         ready_q   <= 1'b1;
         head_data <= '0;
         head_dest <= '0;
         skid_data <= '0;
         skid_dest <= '0;
      end else begin
         occ_q   <= occ_d;
         ready_q <= (occ_d < 2'd2);
         if (xfer) begin
            // The skid entry is always older than anything arriving this cycle.
            if (occ_q == 2'd2) begin
               head_data <= skid_data;
               head_dest <= skid_dest;
               if (accept) begin
                  skid_data <= bus.alu_out;
                  skid_dest <= bus.dest_in;
               end
            end else if (accept) begin
               head_data <= bus.alu_out;
               head_dest <= bus.dest_in;
            end
         end else if (accept) begin
            if (occ_q == 2'd0) begin
               head_data <= bus.alu_out;
               head_dest <= bus.dest_in;
            end else begin
               skid_data <= bus.alu_out;
               skid_dest <= bus.dest_in;
            end
         end
      end
   end
`else
   assign bus.in_ready = (occ_q == 2'd0) || bus.out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q     <= 2'd0;
         head_data <= '0;
         head_dest <= '0;
      end else begin
         occ_q <= occ_d;
         if (accept) begin
            head_data <= bus.alu_out;
            head_dest <= bus.dest_in;
         end
      end
   end
`endif

   // Flags follow the accept edge so the very next ALU op sees the updated carry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flag_c <= 1'b0;
         flag_z <= 1'b0;
         flag_n <= 1'b0;
      end else if (flags_clr) begin
         flag_c <= 1'b0;
         flag_z <= 1'b0;
         flag_n <= 1'b0;
      end else if (accept && bus.wr_flags_in) begin
         flag_z <= (bus.alu_out == '0);
         flag_n <= bus.alu_out[WIDTH-1];
         if (bus.alu_sel_in == 4'b0000 || bus.alu_sel_in == 4'b0001 ||
             bus.alu_sel_in == 4'b1101)
            flag_c <= bus.alu_c_out;
      end
   end
endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - Directed scoreboard bench for alu_result_stage.
// Expectations follow ALU_RESULT_SKID_EN when the bench is built with it.
module tb_alu_result_stage;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flags_clr = 1'b0;
   logic       flag_c, flag_z, flag_n;
   logic [1:0] occupancy;

   int checks = 0;
   int errors = 0;

   logic [19:0] sb[$];
   int          occ_m = 0;
   logic        fc_m = 1'b0, fz_m = 1'b0, fn_m = 1'b0;
   int          cyc = 0;
   int          peak = 0;

   alu_result_stage_if #(.WIDTH(16), .DEST_W(4)) bus ();

   alu_result_stage #(.WIDTH(16), .DEST_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .flags_clr (flags_clr),
      .flag_c    (flag_c),
      .flag_z    (flag_z),
      .flag_n    (flag_n),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [15:0] d, input logic c,
                        input logic [3:0] sel, input logic [3:0] dest, input logic wr);
      bus.in_valid    = v;
      bus.alu_out     = d;
      bus.alu_c_out   = c;
      bus.alu_sel_in  = sel;
      bus.dest_in     = dest;
      bus.wr_flags_in = wr;
   endtask

   // One clock: check handshake state before the edge, then flags and occupancy after it.
   task automatic cycle(output logic acc);
      logic        xf;
      logic        rdy_exp;
      logic [19:0] e;
      #1;
`ifdef ALU_RESULT_SKID_EN
      rdy_exp = (occ_m < 2);
`else
      rdy_exp = (occ_m == 0) || bus.out_ready;
`endif
      chk("in_ready", bus.in_ready, rdy_exp);
      chk("occupancy", occupancy, occ_m);
      chk("out_valid", bus.out_valid, occ_m != 0);
      acc = bus.in_valid && bus.in_ready;
      xf  = bus.out_valid && bus.out_ready;
      if (xf) begin
         chk("sb_nonempty", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("wb_data", bus.wb_data, e[19:4]);
            chk("wb_dest", bus.wb_dest, e[3:0]);
         end
      end
      if (acc) sb.push_back({bus.alu_out, bus.dest_in});
      if (flags_clr) begin
         fc_m = 1'b0; fz_m = 1'b0; fn_m = 1'b0;
      end else if (acc && bus.wr_flags_in) begin
         fz_m = (bus.alu_out == 16'h0000);
         fn_m = bus.alu_out[15];
         if (bus.alu_sel_in == 4'd0 || bus.alu_sel_in == 4'd1 || bus.alu_sel_in == 4'd13)
            fc_m = bus.alu_c_out;
      end
      occ_m = occ_m + (acc ? 1 : 0) - (xf ? 1 : 0);
      @(posedge clk);
      #1;
      chk("flag_c", flag_c, fc_m);
      chk("flag_z", flag_z, fz_m);
      chk("flag_n", flag_n, fn_m);
      if (occupancy > peak) peak = occupancy;
      @(negedge clk);
      cyc++;
   endtask

   task automatic drain();
      logic a;
      drive(1'b0, 16'h0, 1'b0, 4'h0, 4'h0, 1'b0);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10 && occ_m != 0; i++) cycle(a);
      chk("drain_occ", occupancy, 0);
      chk("drain_sb", sb.size(), 0);
   endtask

   initial begin
      logic a;
      logic [15:0] stream_d[4];
      int k;
      stream_d[0] = 16'h1111; stream_d[1] = 16'h2222;
      stream_d[2] = 16'h0000; stream_d[3] = 16'hF00D;

      drive(1'b0, 16'h0, 1'b0, 4'h0, 4'h0, 1'b0);
      bus.out_ready = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_occ", occupancy, 0);
      chk("rst_flags", {flag_c, flag_z, flag_n}, 3'b000);
      chk("rst_wb_data", bus.wb_data, 16'h0000);
      chk("rst_wb_dest", bus.wb_dest, 4'h0);
      @(negedge clk);
      rst = 1'b0;
      cycle(a);

      // Zero result with carry from ADD.
      drive(1'b1, 16'h0000, 1'b1, 4'b0000, 4'd3, 1'b1);
      cycle(a);
      chk("r37_accept", a, 1);
      #1;
      chk("r37_valid", bus.out_valid, 1);
      chk("r37_wb_data", bus.wb_data, 16'h0000);
      chk("r37_wb_dest", bus.wb_dest, 4'd3);
      chk("r37_flags", {flag_c, flag_z, flag_n}, 3'b110);

      // Negative result from an op that leaves carry alone.
      drive(1'b1, 16'h8001, 1'b0, 4'b0010, 4'd5, 1'b1);
      bus.out_ready = 1'b1;
      cycle(a);
      chk("r38_accept", a, 1);
      chk("r38_flags", {flag_c, flag_z, flag_n}, 3'b101);
      drive(1'b1, 16'h0042, 1'b0, 4'b1101, 4'd6, 1'b1);
      cycle(a);
      chk("sel1101_flags", {flag_c, flag_z, flag_n}, 3'b000);
      drive(1'b1, 16'h8000, 1'b1, 4'b0001, 4'd7, 1'b0);
      cycle(a);
      chk("nowr_flags", {flag_c, flag_z, flag_n}, 3'b000);
      drain();

      // Four-entry stream with two stalled cycles.
      peak = 0;
      cyc = 1;
      k = 0;
      for (int i = 0; i < 20 && k < 4; i++) begin
         drive(1'b1, stream_d[k], k[0], 4'b0001, 4'(8 + k), 1'b1);
         bus.out_ready = !(cyc == 2 || cyc == 3);
         cycle(a);
         if (a) k++;
      end
      chk("stream_accepted", k, 4);
      drain();
`ifdef ALU_RESULT_SKID_EN
      chk("stream_peak", peak, 2);
`else
      chk("stream_peak", peak, 1);
`endif

      // Clear beats a simultaneous flag update; entry still delivered.
      drive(1'b1, 16'h8000, 1'b1, 4'b0000, 4'd1, 1'b1);
      cycle(a);
      drive(1'b1, 16'h0000, 1'b1, 4'b0000, 4'd2, 1'b1);
      flags_clr = 1'b1;
      cycle(a);
      chk("clr_accept", a, 1);
      chk("clr_flags", {flag_c, flag_z, flag_n}, 3'b000);
      flags_clr = 1'b0;
      drain();

      // Fill, then reset mid-cycle.
      bus.out_ready = 1'b0;
      drive(1'b1, 16'hAAAA, 1'b0, 4'b0000, 4'd11, 1'b1);
      cycle(a);
      drive(1'b1, 16'hBBBB, 1'b0, 4'b0000, 4'd12, 1'b1);
      cycle(a);
`ifdef ALU_RESULT_SKID_EN
      chk("fill_occ", occupancy, 2);
`else
      chk("fill_occ", occupancy, 1);
`endif
      drive(1'b0, 16'h0, 1'b0, 4'h0, 4'h0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", bus.out_valid, 0);
      chk("arst_occ", occupancy, 0);
      chk("arst_flags", {flag_c, flag_z, flag_n}, 3'b000);
      chk("arst_wb_data", bus.wb_data, 16'h0000);
      sb.delete();
      occ_m = 0;
      fc_m = 1'b0; fz_m = 1'b0; fn_m = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) cycle(a);
      chk("post_rst_valid", bus.out_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
